// File: rtl/processor_control_unit_pkg.sv
// Shared definitions for the processor control unit: opcodes, Tstep encodings,
// bus-select constants and the control-word decoder.
package processor_control_unit_pkg;

  localparam int IR_W    = 8;
  localparam int REG_CNT = 4;
  localparam int SEL_W   = 5;

  typedef enum logic [1:0] {
    OP_MV  = 2'b00,
    OP_MVI = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_e;

  localparam logic [SEL_W-1:0] SEL_NONE = 5'b00000;
  localparam logic [SEL_W-1:0] SEL_R0   = 5'b00001;
  localparam logic [SEL_W-1:0] SEL_R1   = 5'b00010;
  localparam logic [SEL_W-1:0] SEL_R2   = 5'b00100;
  localparam logic [SEL_W-1:0] SEL_R3   = 5'b01000;
  localparam logic [SEL_W-1:0] SEL_DIN  = 5'b10000;

  typedef struct packed {
    logic [SEL_W-1:0]   s;
    logic [REG_CNT-1:0] rin;
    logic               ain;
    logic               gin;
    logic               gout;
    logic               addsub;
    logic               done;
  } ctrl_t;

  function automatic logic [SEL_W-1:0] sel_reg(input logic [1:0] r);
    return SEL_R0 << r;
  endfunction

  function automatic logic [REG_CNT-1:0] rin_onehot(input logic [1:0] r);
    return REG_CNT'(1) << r;
  endfunction

  // ir_hi is IR[7:2]; the two low instruction bits never affect decode.
  function automatic ctrl_t decode(input tstep_e t, input logic [5:0] ir_hi);
    ctrl_t      c;
    opcode_e    op;
    logic [1:0] x;
    logic [1:0] y;
    c  = '0;
    op = opcode_e'(ir_hi[5:4]);
    x  = ir_hi[3:2];
    y  = ir_hi[1:0];
    unique case (t)
      T0: ;
      T1: begin
        if (op == OP_MV) begin
          c.s    = sel_reg(y);
          c.rin  = rin_onehot(x);
          c.done = 1'b1;
        end else if (op == OP_MVI) begin
          c.s    = SEL_DIN;
          c.rin  = rin_onehot(x);
          c.done = 1'b1;
        end else begin
          c.s   = sel_reg(x);
          c.ain = 1'b1;
        end
      end
      T2: begin
        c.s      = sel_reg(y);
        c.gin    = 1'b1;
        c.addsub = (op == OP_SUB);
      end
      T3: begin
        c.s    = SEL_NONE;
        c.gout = 1'b1;
        c.rin  = rin_onehot(x);
        c.done = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/processor_control_unit_if.sv
// Control-unit bus: instruction/run inputs and datapath control outputs.
interface processor_control_unit_if #(
  parameter int DATA_W = 8,
  parameter int NREG   = 4
);
  logic              Run;
  logic [DATA_W-1:0] DIN;
  logic [4:0]        S;
  logic [NREG-1:0]   Rin;
  logic              Ain;
  logic              Gin;
  logic              Gout;
  logic              AddSub;
  logic [DATA_W-1:0] IR;
  logic              Done;

  modport master (
    output Run, DIN,
    input  S, Rin, Ain, Gin, Gout, AddSub, IR, Done
  );

  modport slave (
    input  Run, DIN,
    output S, Rin, Ain, Gin, Gout, AddSub, IR, Done
  );
endinterface

// File: rtl/processor_control_unit_regn.sv
// Enabled register with asynchronous active-low clear; used as the instruction register.
module processor_control_unit_regn #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;
endmodule

// File: rtl/processor_control_unit.sv
// Instruction-sequencing FSM: fetches an instruction in T0 and steps T1..T3,
// driving bus select, register enables and ALU controls for the datapath.
module processor_control_unit
  import processor_control_unit_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREG   = 4
) (
  input logic                     Clk,
  input logic                     Resetn,
  processor_control_unit_if.slave bus
);
  tstep_e            tstep_q;
  tstep_e            tstep_d;
  logic              irin;
  logic [DATA_W-1:0] ir_q;
  logic [5:0]        ir_dec_d;
  ctrl_t             ctrl_q;

  assign irin = (tstep_q == T0) && bus.Run;

  processor_control_unit_regn #(.W(DATA_W)) u_ir (
    .clk_i  (Clk),
    .rst_ni (Resetn),
    .en_i   (irin),
    .d_i    (bus.DIN),
    .q_o    (ir_q)
  );

  // Outputs are registered from the next Tstep/IR, so they show the same
  // per-step values as a combinational decode of the current Tstep/IR.
  assign ir_dec_d = irin ? bus.DIN[DATA_W-1:DATA_W-6] : ir_q[DATA_W-1:DATA_W-6];

  always_comb begin
    tstep_d = tstep_q;
    unique case (tstep_q)
      T0: tstep_d = bus.Run ? T1 : T0;
      T1: tstep_d = (ir_q[DATA_W-1] == 1'b0) ? T0 : T2;
      T2: tstep_d = T3;
      T3: tstep_d = T0;
      default: tstep_d = T0;
    endcase
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      tstep_q <= T0;
      ctrl_q  <= '0;
    end else begin
      tstep_q <= tstep_d;
      ctrl_q  <= decode(tstep_d, ir_dec_d);
    end
  end

  assign bus.S      = ctrl_q.s;
  assign bus.Rin    = NREG'(ctrl_q.rin);
  assign bus.Ain    = ctrl_q.ain;
  assign bus.Gin    = ctrl_q.gin;
  assign bus.Gout   = ctrl_q.gout;
  assign bus.AddSub = ctrl_q.addsub;
  assign bus.Done   = ctrl_q.done;
  assign bus.IR     = ir_q;
endmodule

// File: tb/tb_processor_control_unit.sv
// Self-checking bench for processor_control_unit: per-instruction schedule model
// checked every cycle, plus directed literal expectations.
module tb_processor_control_unit;
  logic Clk = 1'b0;
  logic Resetn;
  int   checks   = 0;
  int   failures = 0;

  processor_control_unit_if #(.DATA_W(8), .NREG(4)) bus ();

  processor_control_unit #(.DATA_W(8), .NREG(4)) dut (
    .Clk    (Clk),
    .Resetn (Resetn),
    .bus    (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [4:0] s;
    logic [3:0] rin;
    logic       ain;
    logic       gin;
    logic       gout;
    logic       addsub;
    logic       done;
  } exp_t;

  exp_t       sched[$];
  logic [7:0] model_ir = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expand an instruction into the control word of each step after fetch.
  task automatic push_instr(input logic [7:0] ins);
    exp_t       e;
    logic [1:0] op;
    logic [4:0] sx;
    logic [4:0] sy;
    logic [3:0] rx;
    op = ins[7:6];
    sx = 5'd1 << ins[5:4];
    sy = 5'd1 << ins[3:2];
    rx = 4'd1 << ins[5:4];
    if (op == 2'b00) begin
      e = '{s: sy, rin: rx, ain: 1'b0, gin: 1'b0, gout: 1'b0, addsub: 1'b0, done: 1'b1};
      sched.push_back(e);
    end else if (op == 2'b01) begin
      e = '{s: 5'b10000, rin: rx, ain: 1'b0, gin: 1'b0, gout: 1'b0, addsub: 1'b0, done: 1'b1};
      sched.push_back(e);
    end else begin
      e = '{s: sx, rin: 4'b0, ain: 1'b1, gin: 1'b0, gout: 1'b0, addsub: 1'b0, done: 1'b0};
      sched.push_back(e);
      e = '{s: sy, rin: 4'b0, ain: 1'b0, gin: 1'b1, gout: 1'b0, addsub: (op == 2'b11), done: 1'b0};
      sched.push_back(e);
      e = '{s: 5'b0, rin: rx, ain: 1'b0, gin: 1'b0, gout: 1'b1, addsub: 1'b0, done: 1'b1};
      sched.push_back(e);
    end
  endtask

  always @(negedge Clk) begin
    exp_t e;
    logic idle;
    idle = 1'b0;
    e    = '0;
    if (!Resetn) begin
      sched.delete();
      model_ir = 8'h00;
    end else begin
      idle = (sched.size() == 0);
      if (!idle) e = sched.pop_front();
    end
    chk("cycle", {10'b0, bus.S, bus.Rin, bus.Ain, bus.Gin, bus.Gout, bus.AddSub, bus.Done, bus.IR},
                 {10'b0, e, model_ir});
    if (Resetn && idle && bus.Run) begin
      push_instr(bus.DIN);
      model_ir = bus.DIN;
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  logic [7:0] ins_tab [2] = '{8'hD8, 8'h98};
  logic       as_tab  [2] = '{1'b1, 1'b0};
  logic       run_tab [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [7:0] din_tab [8] = '{8'h50, 8'h77, 8'hA4, 8'h00, 8'h00, 8'h00, 8'h30, 8'h00};
  logic [7:0] done_mask;
  logic [7:0] ir_seen [9];

  initial begin
    Resetn  = 1'b0;
    bus.Run = 1'b1;
    bus.DIN = 8'h60;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_S", 32'(bus.S), 32'h0);
    chk("rst_Rin", 32'(bus.Rin), 32'h0);
    chk("rst_Done", 32'(bus.Done), 32'h0);
    chk("rst_IR", 32'(bus.IR), 32'h0);

    Resetn  = 1'b1;
    bus.Run = 1'b0;
    repeat (5) step();
    chk("idle_S", 32'(bus.S), 32'h0);
    chk("idle_Done", 32'(bus.Done), 32'h0);
    chk("idle_IR", 32'(bus.IR), 32'h0);

    // mvi R2,#0x5A
    bus.Run = 1'b1; bus.DIN = 8'h60;
    step();
    bus.Run = 1'b0; bus.DIN = 8'h5A;
    chk("mvi_S", 32'(bus.S), 32'b10000);
    chk("mvi_Rin", 32'(bus.Rin), 32'b0100);
    chk("mvi_Done", 32'(bus.Done), 32'h1);
    chk("mvi_IR", 32'(bus.IR), 32'h60);
    step();
    chk("mvi_T0_Done", 32'(bus.Done), 32'h0);
    chk("mvi_T0_S", 32'(bus.S), 32'h0);

    // mv R0,R3
    bus.Run = 1'b1; bus.DIN = 8'h0C;
    step();
    bus.Run = 1'b0;
    chk("mv_S", 32'(bus.S), 32'b01000);
    chk("mv_Rin", 32'(bus.Rin), 32'b0001);
    chk("mv_Done", 32'(bus.Done), 32'h1);
    step();
    chk("mv_end_Done", 32'(bus.Done), 32'h0);

    // sub R1,R2 then add R1,R2
    for (int i = 0; i < 2; i++) begin
      bus.Run = 1'b1; bus.DIN = ins_tab[i];
      step();
      bus.Run = 1'b0;
      chk("as_T1_S", 32'(bus.S), 32'b00010);
      chk("as_T1_Ain", 32'(bus.Ain), 32'h1);
      chk("as_T1_Done", 32'(bus.Done), 32'h0);
      step();
      chk("as_T2_S", 32'(bus.S), 32'b00100);
      chk("as_T2_Gin", 32'(bus.Gin), 32'h1);
      chk("as_T2_AddSub", 32'(bus.AddSub), 32'(as_tab[i]));
      step();
      chk("as_T3_Gout", 32'(bus.Gout), 32'h1);
      chk("as_T3_S", 32'(bus.S), 32'h0);
      chk("as_T3_Rin", 32'(bus.Rin), 32'b0010);
      chk("as_T3_Done", 32'(bus.Done), 32'h1);
      step();
      chk("as_end_Done", 32'(bus.Done), 32'h0);
    end

    // Back-to-back mvi, add, mv with Run mostly held high
    for (int c = 1; c <= 8; c++) begin
      done_mask[c-1] = bus.Done;
      ir_seen[c]     = bus.IR;
      bus.Run        = run_tab[c-1];
      bus.DIN        = din_tab[c-1];
      step();
    end
    chk("b2b_done_cycles", 32'(done_mask), 32'b1010_0010);
    chk("b2b_ir_c2", 32'(ir_seen[2]), 32'h50);
    chk("b2b_ir_c3", 32'(ir_seen[3]), 32'h50);
    chk("b2b_ir_c4", 32'(ir_seen[4]), 32'hA4);
    chk("b2b_ir_c8", 32'(ir_seen[8]), 32'h30);

    // Reset in T2 of add R3,R0
    bus.Run = 1'b1; bus.DIN = 8'hB0;
    step();
    bus.Run = 1'b0;
    step();
    chk("r6_T2_Gin", 32'(bus.Gin), 32'h1);
    Resetn = 1'b0;
    #1;
    chk("r6_S", 32'(bus.S), 32'h0);
    chk("r6_Gin", 32'(bus.Gin), 32'h0);
    chk("r6_Rin", 32'(bus.Rin), 32'h0);
    chk("r6_Done", 32'(bus.Done), 32'h0);
    chk("r6_IR", 32'(bus.IR), 32'h0);
    @(posedge Clk);
    #1;
    chk("r6_hold_Rin", 32'(bus.Rin), 32'h0);
    chk("r6_hold_Gout", 32'(bus.Gout), 32'h0);
    Resetn = 1'b1;
    repeat (3) step();
    chk("r6_after_Done", 32'(bus.Done), 32'h0);
    chk("r6_after_S", 32'(bus.S), 32'h0);

    // mv R1,R1 with nonzero IR[1:0]
    bus.Run = 1'b1; bus.DIN = 8'h17;
    step();
    bus.Run = 1'b0;
    chk("mvxx_S", 32'(bus.S), 32'b00010);
    chk("mvxx_Rin", 32'(bus.Rin), 32'b0010);
    chk("mvxx_Done", 32'(bus.Done), 32'h1);
    chk("mvxx_IR", 32'(bus.IR), 32'h17);
    step();

    // add R1,R1
    bus.Run = 1'b1; bus.DIN = 8'h97;
    step();
    bus.Run = 1'b0;
    step();
    chk("addxx_T2_S", 32'(bus.S), 32'b00010);
    step();
    chk("addxx_T3_Rin", 32'(bus.Rin), 32'b0010);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
